core_ctrl: RTL
==============

CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 Parameter FETCH_TIMEOUT, default 16, max cycles FETCH waits for imem_valid before trapping.
REQ-002 Parameter CNT_W, default 32, width of retire counter.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 imem_req  out  1  instruction fetch request to i_mem at current PC.
REQ-006 imem_valid  in  1  fetched instruction valid this cycle.
REQ-007 ir_load  out  1  capture instruction word into instruction register.
REQ-008 is_add, is_addi, is_beq, is_bne, is_blt, is_bge, is_bltu, is_bgeu  in  1 each  decode flags.
REQ-009 incorrect  in  1  decoder illegal-instruction flag.
REQ-010 rd_zero  in  1  decoded rd == x0.
REQ-011 cmp_eq, cmp_lt, cmp_ltu  in  1 each  rs1 vs rs2 compare results (equal, signed less, unsigned less).
REQ-012 rf_rd_en1, rf_rd_en2  out  1 each  register file read enables.
REQ-013 rf_wr_en  out  1  register file write enable.
REQ-014 alu_src_imm  out  1  ALU operand B = immediate (1) or rs2 (0).
REQ-015 pc_en  out  1  PC update strobe.
REQ-016 pc_sel  out  1  next PC: 0 = PC+4, 1 = PC+imm.
REQ-017 halted  out  1  core trapped; sticky until reset.
REQ-018 halt_cause  out  2  0 none, 1 illegal instruction, 2 fetch timeout.
REQ-019 retire_cnt  out  CNT_W  retired-instruction count.
REQ-020 state_dbg  out  3  current FSM state encoding.

Function
REQ-021 FSM states IDLE, FETCH, DECODE, EXEC, WB, HALT; IDLE -> FETCH unconditionally next cycle.
REQ-022 FETCH: imem_req=1 every cycle; on imem_valid=1, ir_load=1 same cycle, -> DECODE.
REQ-023 FETCH timeout counter starts at 0 on FETCH entry; reaching FETCH_TIMEOUT cycles without imem_valid -> HALT, halt_cause=2; imem_valid on the final cycle wins over timeout.
REQ-024 DECODE: rf_rd_en1=1; rf_rd_en2=1 except for addi; illegal if incorrect=1 or decode flags not exactly one-hot -> HALT, halt_cause=1; else -> EXEC.
REQ-025 EXEC: alu_src_imm=1 for addi only, 0 otherwise; branch decision registered: beq=cmp_eq, bne=!cmp_eq, blt=cmp_lt, bge=!cmp_lt, bltu=cmp_ltu, bgeu=!cmp_ltu; -> WB.
REQ-026 WB: pc_en=1 for exactly one cycle; pc_sel=registered branch decision (0 for add/addi); rf_wr_en=1 for add/addi only when rd_zero=0; retire_cnt increments; -> FETCH.
REQ-027 Latency: 4 cycles per instruction (FETCH..WB) with zero-wait imem_valid; each wait cycle adds one.
REQ-028 retire_cnt wraps from 2^CNT_W-1 to 0 without flag.
REQ-029 HALT: all strobes (imem_req, ir_load, rf_*_en, pc_en) 0; halted=1; halt_cause held; only exit is reset.
REQ-030 All outputs except retire_cnt, halted, halt_cause, state_dbg are decoded from current state and registered decisions; no strobe asserted outside its listed state.
REQ-031 Decode flags and compare inputs sampled only in DECODE/EXEC; changes elsewhere ignored.

Reset
REQ-032 On reset assertion: state=IDLE, all strobes 0, halted=0, halt_cause=0, retire_cnt=0, timeout counter=0, branch decision=0, regardless of current state.
REQ-033 Reset mid-WB suppresses that retire: no pc_en, rf_wr_en or counter increment after reset asserts.
REQ-034 First imem_req asserted in second cycle after reset deassertion (IDLE, then FETCH).

Structure
REQ-035 Shared package core_pkg holds ctrl_state_t enum, halt_cause_t enum, and HALT_NONE/HALT_ILLEGAL/HALT_TIMEOUT constants.
REQ-036 One combinational sub-module branch_cond computes the taken decision from branch flags and cmp_* inputs.
REQ-037 FSM, timeout counter and retire counter live in core_ctrl; no other sub-modules.

Verification
REQ-038 addi, rd_zero=0, imem_valid in first FETCH cycle -> rf_wr_en and pc_en high in cycle 4, pc_sel=0, retire_cnt 0->1.
REQ-039 beq with cmp_eq=1 -> WB pc_en=1, pc_sel=1, rf_wr_en=0; bgeu with cmp_ltu=1 -> pc_sel=0.
REQ-040 imem_valid withheld 16 cycles (FETCH_TIMEOUT=16) -> HALT, halted=1, halt_cause=2, strobes 0 thereafter.
REQ-041 is_add and is_beq both 1 in DECODE -> HALT, halt_cause=1; incorrect=1 alone -> same.
REQ-042 add with rd_zero=1 -> rf_wr_en stays 0, pc_en=1, retire_cnt increments.
REQ-043 reset pulsed during WB and during HALT -> state_dbg=IDLE, halted=0, retire_cnt=0, no pc_en that cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the core control unit.
package core_pkg;

  // Control FSM states; the encoding is visible on state_dbg.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } ctrl_state_t;

  // Reason the core stopped.
  typedef enum logic [1:0] {
    HC_NONE    = 2'd0,
    HC_ILLEGAL = 2'd1,
    HC_TIMEOUT = 2'd2
  } halt_cause_t;

  localparam halt_cause_t HALT_NONE    = HC_NONE;
  localparam halt_cause_t HALT_ILLEGAL = HC_ILLEGAL;
  localparam halt_cause_t HALT_TIMEOUT = HC_TIMEOUT;

  // Number of decode flags that must be exactly one-hot for a legal instruction.
  localparam int NUM_OPS = 8;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [NUM_OPS-1:0] v);
    return (v != '0) && ((v & (v - NUM_OPS'(1))) == '0);
  endfunction

endpackage

// File: rtl/core_ctrl_branch_cond.sv
// Branch-taken decision from the branch type flags and rs1/rs2 compare results.
module branch_cond (
  input  logic is_beq,
  input  logic is_bne,
  input  logic is_blt,
  input  logic is_bge,
  input  logic is_bltu,
  input  logic is_bgeu,
  input  logic cmp_eq,
  input  logic cmp_lt,
  input  logic cmp_ltu,
  output logic taken
);

  // Non-branch instructions have no flag set here, so they never report taken.
  always_comb begin
    taken = (is_beq  &  cmp_eq)  |
            (is_bne  & !cmp_eq)  |
            (is_blt  &  cmp_lt)  |
            (is_bge  & !cmp_lt)  |
            (is_bltu &  cmp_ltu) |
            (is_bgeu & !cmp_ltu);
  end

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle control FSM: fetch, decode, execute, write-back, with fetch
// timeout and illegal-instruction traps and a retired-instruction counter.
module core_ctrl
  import core_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 16,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  input  logic             imem_valid,
  output logic             ir_load,
  input  logic             is_add,
  input  logic             is_addi,
  input  logic             is_beq,
  input  logic             is_bne,
  input  logic             is_blt,
  input  logic             is_bge,
  input  logic             is_bltu,
  input  logic             is_bgeu,
  input  logic             incorrect,
  input  logic             rd_zero,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  input  logic             cmp_ltu,
  output logic             rf_rd_en1,
  output logic             rf_rd_en2,
  output logic             rf_wr_en,
  output logic             alu_src_imm,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [2:0]       state_dbg
);

  localparam int TO_W = $clog2(FETCH_TIMEOUT + 1);

  ctrl_state_t        state_reg, state_next;
  logic [TO_W-1:0]    to_cnt_reg;
  logic               taken_reg;
  logic               addi_reg;
  logic               wr_ok_reg;
  halt_cause_t        cause_reg;
  logic [CNT_W-1:0]   retire_cnt_reg;

  logic [NUM_OPS-1:0] dec_flags;
  logic               legal;
  logic               timeout_hit;
  logic               branch_taken;

  assign dec_flags   = {is_add, is_addi, is_beq, is_bne, is_blt, is_bge, is_bltu, is_bgeu};
  assign legal       = !incorrect && is_onehot(dec_flags);
  // Last allowed wait cycle; a valid arriving in this same cycle still wins.
  assign timeout_hit = (to_cnt_reg == TO_W'(FETCH_TIMEOUT - 1));

  branch_cond u_branch_cond (
    .is_beq  (is_beq),
    .is_bne  (is_bne),
    .is_blt  (is_blt),
    .is_bge  (is_bge),
    .is_bltu (is_bltu),
    .is_bgeu (is_bgeu),
    .cmp_eq  (cmp_eq),
    .cmp_lt  (cmp_lt),
    .cmp_ltu (cmp_ltu),
    .taken   (branch_taken)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and strobe decode; strobes depend only on state and registered decisions
  // (plus imem_valid/is_addi in the states that sample them).
  always_comb begin
    state_next  = state_reg;
    imem_req    = 1'b0;
    ir_load     = 1'b0;
    rf_rd_en1   = 1'b0;
    rf_rd_en2   = 1'b0;
    rf_wr_en    = 1'b0;
    alu_src_imm = 1'b0;
    pc_en       = 1'b0;
    pc_sel      = 1'b0;
    case (state_reg)
      IDLE:   state_next = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_valid;
        if (imem_valid)       state_next = DECODE;
        else if (timeout_hit) state_next = HALT;
      end
      DECODE: begin
        rf_rd_en1  = 1'b1;
        rf_rd_en2  = !is_addi;
        state_next = legal ? EXEC : HALT;
      end
      EXEC: begin
        alu_src_imm = addi_reg;
        state_next  = WB;
      end
      WB: begin
        pc_en      = 1'b1;
        pc_sel     = taken_reg;
        rf_wr_en   = wr_ok_reg;
        state_next = FETCH;
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Fetch wait counter: runs only while staying in FETCH, zero on every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   to_cnt_reg <= '0;
    else if (state_reg == FETCH) to_cnt_reg <= to_cnt_reg + TO_W'(1);
    else                         to_cnt_reg <= '0;
  end

  // Capture instruction class in DECODE and branch outcome in EXEC so later states ignore inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addi_reg  <= 1'b0;
      wr_ok_reg <= 1'b0;
      taken_reg <= 1'b0;
    end else begin
      if (state_reg == DECODE) begin
        addi_reg  <= is_addi;
        wr_ok_reg <= (is_add | is_addi) & !rd_zero;
      end
      if (state_reg == EXEC) taken_reg <= branch_taken;
    end
  end

  // Sticky trap cause, recorded on the transition into HALT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cause_reg <= HALT_NONE;
    else if (state_next == HALT && state_reg != HALT)
      cause_reg <= (state_reg == FETCH) ? HALT_TIMEOUT : HALT_ILLEGAL;
  end

  // Retire counter, one per write-back, wrapping silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                retire_cnt_reg <= '0;
    else if (state_reg == WB) retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
  end

  assign halted     = (state_reg == HALT);
  assign halt_cause = cause_reg;
  assign retire_cnt = retire_cnt_reg;
  assign state_dbg  = state_reg;

endmodule
